// File: rtl/counter_32bit_pkg.sv
// rtl/counter_32bit_pkg.sv - shared widths, types and constants for the 32-bit timebase counter
package counter_32bit_pkg;

  localparam int COUNT_W = 32;
  // Kogge-Stone prefix depth for a COUNT_W-bit carry
  localparam int PREFIX_LEVELS = $clog2(COUNT_W);

  typedef logic [COUNT_W-1:0] count_t;

  localparam count_t COUNT_MAX = '1;

endpackage

// File: rtl/counter_32bit_incr.sv
// rtl/counter_32bit_incr.sv - combinational Kogge-Stone +1 incrementer
// The carry into bit i is the AND of a[i-1:0], built as a log-depth prefix AND.
module counter_32bit_incr
  import counter_32bit_pkg::*;
(
  input  count_t a,
  output count_t sum,
  output logic   cout
);

  // pre[k][i] = AND of a[i : i-2^k+1] (clipped at bit 0)
  logic [PREFIX_LEVELS:0][COUNT_W-1:0] pre;
  count_t carry;

  assign pre[0] = a;

  for (genvar k = 0; k < PREFIX_LEVELS; k++) begin : g_level
    for (genvar i = 0; i < COUNT_W; i++) begin : g_bit
      if (i >= (1 << k)) begin : g_merge
        assign pre[k+1][i] = pre[k][i] & pre[k][i-(1<<k)];
      end else begin : g_pass
        assign pre[k+1][i] = pre[k][i];
      end
    end
  end

  // The +1 is a carry-in of 1 at bit 0
  assign carry = {pre[PREFIX_LEVELS][COUNT_W-2:0], 1'b1};
  assign sum   = a ^ carry;
  assign cout  = pre[PREFIX_LEVELS][COUNT_W-1];

endmodule

// File: rtl/counter_32bit.sv
// rtl/counter_32bit.sv - 32-bit up-counter with clear, load, enable and registered wrap flag
// Optional macro COUNTER_32BIT_SATURATE_EN: saturate at all-ones instead of wrapping.
module counter_32bit
  import counter_32bit_pkg::*;
#(
  parameter count_t RESET_VALUE = 32'h0000_0000
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_enable,
  input  logic               i_clear,
  input  logic               i_load,
  input  logic [COUNT_W-1:0] i_load_value,
  output logic [COUNT_W-1:0] o_count,
  output logic               o_wrap
);

  count_t count_q;
  logic   wrap_q;
  count_t incr_sum;
  logic   incr_cout;

  counter_32bit_incr u_incr (
    .a    (count_q),
    .sum  (incr_sum),
    .cout (incr_cout)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      count_q <= RESET_VALUE;
      wrap_q  <= 1'b0;
    end else if (i_clear) begin
      count_q <= '0;
      wrap_q  <= 1'b0;
    end else if (i_load) begin
      count_q <= i_load_value;
      wrap_q  <= 1'b0;
    end else if (i_enable) begin
`ifdef COUNTER_32BIT_SATURATE_EN
      // A carry-out means the count is already at COUNT_MAX: stick there
      if (incr_cout) begin
        count_q <= COUNT_MAX;
        wrap_q  <= 1'b0;
      end else begin
        count_q <= incr_sum;
        wrap_q  <= (incr_sum == COUNT_MAX);
      end
`else
      count_q <= incr_sum;
      wrap_q  <= incr_cout;
`endif
    end else begin
      wrap_q <= 1'b0;
    end
  end

  assign o_count = count_q;
  assign o_wrap  = wrap_q;

endmodule

// File: tb/tb_counter_32bit.sv
// tb/tb_counter_32bit.sv - scoreboard bench for counter_32bit with directed vectors
module tb_counter_32bit;

  typedef struct {
    logic [31:0] count;
    logic        wrap;
    int          id;
  } exp_t;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b1;
  logic        i_enable = 1'b0;
  logic        i_clear = 1'b0;
  logic        i_load = 1'b0;
  logic [31:0] i_load_value = '0;
  logic [31:0] o_count;
  logic        o_wrap;

  int   n_checks = 0;
  int   n_errors = 0;
  int   step_id = 0;
  exp_t sb_q[$];

  counter_32bit dut (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_enable     (i_enable),
    .i_clear      (i_clear),
    .i_load       (i_load),
    .i_load_value (i_load_value),
    .o_count      (o_count),
    .o_wrap       (o_wrap)
  );

  always #5 i_clk = ~i_clk;

  task automatic check(input string name, input int id, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s step %0d: got %h expected %h", name, id, got, exp);
    end
  endtask

  // Drive one cycle of controls and queue the post-edge expectation
  task automatic step(input logic clr, input logic ld, input logic [31:0] val,
                      input logic en, input logic [31:0] exp_count, input logic exp_wrap);
    exp_t e;
    @(negedge i_clk);
    i_clear      = clr;
    i_load       = ld;
    i_load_value = val;
    i_enable     = en;
    e.count = exp_count;
    e.wrap  = exp_wrap;
    e.id    = step_id;
    step_id++;
    sb_q.push_back(e);
  endtask

  // Monitor: one queued expectation per rising edge, sampled just after it
  always @(posedge i_clk) begin
    exp_t e;
    #1;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check("count", e.id, o_count, e.count);
      check("wrap", e.id, {31'b0, o_wrap}, {31'b0, e.wrap});
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset held for 3 edges, enable high but ignored
    for (int i = 0; i < 3; i++) step(0, 0, 32'h0, 1, 32'h0, 0);
    @(negedge i_clk);
    i_rst = 1'b0;
    i_enable = 1'b0;
    sb_q.push_back('{count: 32'h0, wrap: 1'b0, id: step_id});
    step_id++;
    for (int i = 1; i <= 10; i++) step(0, 0, 32'h0, 1, 32'(i), 0);

    // Enable gating
    step(1, 0, 32'h0, 0, 32'h0, 0);
    for (int i = 1; i <= 5; i++) step(0, 0, 32'h0, 1, 32'(i), 0);
    for (int i = 0; i < 4; i++) step(0, 0, 32'h0, 0, 32'd5, 0);
    for (int i = 6; i <= 8; i++) step(0, 0, 32'h0, 1, 32'(i), 0);

    // Roll-over
    step(0, 1, 32'hFFFF_FFFD, 0, 32'hFFFF_FFFD, 0);
    step(0, 0, 32'h0, 1, 32'hFFFF_FFFE, 0);
`ifdef COUNTER_32BIT_SATURATE_EN
    step(0, 0, 32'h0, 1, 32'hFFFF_FFFF, 1);
    step(0, 0, 32'h0, 1, 32'hFFFF_FFFF, 0);
    step(0, 0, 32'h0, 1, 32'hFFFF_FFFF, 0);
    step(0, 1, 32'hFFFF_FFFF, 0, 32'hFFFF_FFFF, 0);
    step(0, 0, 32'h0, 1, 32'hFFFF_FFFF, 0);
    step(0, 0, 32'h0, 0, 32'hFFFF_FFFF, 0);
`else
    step(0, 0, 32'h0, 1, 32'hFFFF_FFFF, 0);
    step(0, 0, 32'h0, 1, 32'h0000_0000, 1);
    step(0, 0, 32'h0, 1, 32'h0000_0001, 0);
    step(0, 1, 32'hFFFF_FFFF, 0, 32'hFFFF_FFFF, 0);
    step(0, 0, 32'h0, 1, 32'h0000_0000, 1);
    step(0, 0, 32'h0, 0, 32'h0000_0000, 0);
`endif

    // Priority: clear beats load beats enable, never a wrap
    step(0, 1, 32'hFFFF_FFFF, 0, 32'hFFFF_FFFF, 0);
    step(1, 1, 32'h1234_5678, 1, 32'h0, 0);
    step(0, 1, 32'h1234_5678, 1, 32'h1234_5678, 0);
    step(0, 0, 32'h0, 1, 32'h1234_5679, 0);

    // Carry propagation across byte and half-word boundaries
    step(0, 1, 32'h0000_FFFF, 0, 32'h0000_FFFF, 0);
    step(0, 0, 32'h0, 1, 32'h0001_0000, 0);
    step(0, 1, 32'h00FF_FFFF, 0, 32'h00FF_FFFF, 0);
    step(0, 0, 32'h0, 1, 32'h0100_0000, 0);
    step(0, 1, 32'h7FFF_FFFF, 0, 32'h7FFF_FFFF, 0);
    step(0, 0, 32'h0, 1, 32'h8000_0000, 0);

    // Asynchronous reset mid-count
    step(0, 1, 32'h0000_0100, 0, 32'h0000_0100, 0);
    step(0, 0, 32'h0, 1, 32'h0000_0101, 0);
    @(negedge i_clk);
    #2;
    i_rst = 1'b1;
    #1;
    check("async_rst_count", step_id, o_count, 32'h0);
    check("async_rst_wrap", step_id, {31'b0, o_wrap}, 32'h0);
    step(0, 0, 32'h0, 1, 32'h0, 0);
    @(negedge i_clk);
    i_rst = 1'b0;
    i_enable = 1'b0;
    sb_q.push_back('{count: 32'h0, wrap: 1'b0, id: step_id});
    step_id++;
    step(0, 0, 32'h0, 1, 32'h1, 0);
    step(0, 0, 32'h0, 1, 32'h2, 0);

    // Drain the scoreboard, bounded
    for (int i = 0; i < 10 && sb_q.size() > 0; i++) @(posedge i_clk);
    #2;
    check("scoreboard_drained", step_id, 32'(sb_q.size()), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/counter_32bit.md
# counter_32bit

Free-running 32-bit binary up-counter with enable, synchronous clear, parallel load and a registered wrap flag. It is the timebase element of the refined clock datapath: downstream logic samples `o_count` as a cycle timestamp and uses `o_wrap` to extend it to wider epochs. The incrementer is a carry-lookahead (prefix) structure so that a full 32-bit carry closes timing at the system clock.

## Interface
Parameters:
- `RESET_VALUE`, default 32'h0000_0000: value loaded into the count on reset.

Ports:
- `i_clk`, input, 1 bit: the single clock; all state updates on its rising edge.
- `i_rst`, input, 1 bit: reset, asynchronous and active-high.
- `i_enable`, input, 1 bit: count enable; the count advances by 1 per rising edge while this is high.
- `i_clear`, input, 1 bit: synchronous clear to 0.
- `i_load`, input, 1 bit: synchronous parallel load.
- `i_load_value`, input, 32 bits: value written to the count when `i_load` is high.
- `o_count`, output, 32 bits: current count, registered.
- `o_wrap`, output, 1 bit: registered one-cycle pulse marking a roll-over.

## Operation
- Reset (`i_rst`=1, asynchronous, independent of the clock):
  - `o_count` = `RESET_VALUE`.
  - `o_wrap` = 0.
  - Both hold while reset is asserted.
- At each rising edge with `i_rst`=0, one action is taken, in strict priority order:
  1. `i_clear`=1: `o_count` becomes 0 and `o_wrap` becomes 0.
  2. `i_load`=1: `o_count` becomes `i_load_value` and `o_wrap` becomes 0.
  3. `i_enable`=1: `o_count` becomes `o_count`+1, modulo 2^32.
  4. Otherwise `o_count` holds and `o_wrap` becomes 0.
- Arithmetic is unsigned, 32 bits wide; the carry-out of bit 31 is discarded from the count.
- When an increment takes 32'hFFFF_FFFF to 32'h0000_0000, `o_wrap` is 1 for exactly the following cycle.
- Any clear, load or increment that does not roll over leaves `o_wrap` at 0.
- Loading 32'hFFFF_FFFF and then enabling produces a normal wrap.
- Simultaneous `i_clear`, `i_load` and `i_enable`: clear wins, and no wrap is flagged.
- Reset asserted mid-count: the count returns to `RESET_VALUE` immediately, with no clock required. On the first edge after release, normal operation resumes.
- Inputs are sampled only at rising edges; there are no combinational paths from inputs to outputs.

## Timing
- Latency is 1 cycle. A control input sampled at edge N is reflected on `o_count` and `o_wrap` after edge N.
- Throughput is one increment per clock.
- `o_wrap` rises on the same edge on which `o_count` becomes 0 through roll-over, and falls on the next edge.
- Reset release should be synchronised upstream. The counter itself places no synchronous requirement on deassertion beyond standard recovery and removal.
- Critical path: the 32-bit increment. It must be implemented as a log-depth prefix carry, 5 levels, not as a ripple chain.

## Configuration
- Macro `COUNTER_32BIT_SATURATE_EN`.
- Defined:
  - An enabled increment at 32'hFFFF_FFFF holds the count at 32'hFFFF_FFFF.
  - `o_wrap` instead pulses high for one cycle on the edge where the count first reaches 32'hFFFF_FFFF by incrementing.
  - Clear and load still override.
- Not defined: modulo-2^32 wrap, exactly as described in Operation.

## Structure
- Shared package `counter_32bit_pkg`:
  - `COUNT_W` = 32.
  - typedef `count_t` (logic [COUNT_W-1:0]).
  - constant `COUNT_MAX` = all ones.
- Sub-module `counter_32bit_incr`: purely combinational Kogge-Stone increment.
  - Input: `a` (`count_t`).
  - Outputs: `sum` (`count_t`) and `cout` (1 bit).
- The top level holds the count and wrap registers, the priority mux and the saturation logic.

## Test plan
- Reset then count: hold `i_rst`=1 for 3 cycles, then release with `i_enable`=1 for 10 edges. Required: `o_count`=0 during reset, then 1..10; `o_wrap`=0 throughout.
- Enable gating: count to 5, drop `i_enable` for 4 cycles, then re-enable. Required: `o_count` holds at 5, then continues 6, 7, …
- Roll-over: load 32'hFFFF_FFFD, then enable. Required: `o_count` goes FFFF_FFFE, FFFF_FFFF, 0000_0000, 0000_0001. `o_wrap`=1 only in the cycle `o_count`=0; with `COUNTER_32BIT_SATURATE_EN`, the count sticks at FFFF_FFFF and the pulse occurs when the count reaches FFFF_FFFF.
- Priority: with `i_clear`=`i_load`=`i_enable`=1 and `i_load_value`=32'h1234_5678 → `o_count`=0. Drop `i_clear` → `o_count`=32'h1234_5678.
- Asynchronous reset mid-count: at count 32'h0000_0100, assert `i_rst` between clock edges. Required: `o_count`=`RESET_VALUE` immediately, and `o_wrap`=0.
- Carry chain: load 32'h0000_FFFF, 32'h00FF_FFFF and 32'h7FFF_FFFF, one increment each. Required results: 32'h0001_0000, 32'h0100_0000 and 32'h8000_0000.
